// File: rtl/schmidl_cox_preamble_inserter.sv
// ============================================================================
// schmidl_cox_preamble_inserter
//
// Purpose
//   Transmit-side framer that prepends a Schmidl-Cox synchronisation preamble
//   to every outgoing OFDM frame.
//
//   The preamble is read from a small software-loadable RAM that holds one
//   half-symbol of HALF_LEN samples. Each frame is emitted in this order:
//
//     1. an optional cyclic prefix: the last CP_LEN RAM entries, ascending;
//     2. the half-symbol;
//     3. the same half-symbol again;
//     4. exactly len payload samples, copied unmodified from the input
//        stream, with tlast on the final one.
//
//   len is cfg_payload_len latched at frame start; a value of zero is
//   treated as one.
//
// Ports
//   ce_clk, ce_rst        block clock, synchronous active-high reset
//   cfg_enable            frames may start while high (sampled in IDLE only)
//   cfg_payload_len       payload samples per frame, latched at frame start
//   pre_wr_en/addr/data   preamble RAM write port, ignored while busy
//   s_axis_*              payload input stream (tlast is ignored)
//   m_axis_*              framed output stream, fully registered
//   busy                  high from frame start until the tlast handshake
//   frame_cnt             completed frames, wraps at 2^16
// ============================================================================
module schmidl_cox_preamble_inserter #(
    parameter int ITEM_W   = 32,
    parameter int HALF_LEN = 64,
    parameter int CP_LEN   = 16,
    parameter int LEN_W    = 16
) (
    input  logic                        ce_clk,
    input  logic                        ce_rst,
    input  logic                        cfg_enable,
    input  logic [LEN_W-1:0]            cfg_payload_len,
    input  logic                        pre_wr_en,
    input  logic [$clog2(HALF_LEN)-1:0] pre_wr_addr,
    input  logic [ITEM_W-1:0]           pre_wr_data,
    input  logic [ITEM_W-1:0]           s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic                        s_axis_tlast,
    output logic [ITEM_W-1:0]           m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic                        busy,
    output logic [15:0]                 frame_cnt
);

    localparam int ADDR_W = $clog2(HALF_LEN);

    // The cyclic prefix starts CP_LEN entries before the end of the RAM.
    // With CP_LEN = 0 the expression wraps to address 0, which is also where
    // the first half-symbol starts, so one start address serves both cases.
    localparam logic [ADDR_W-1:0] CP_START  = ADDR_W'((HALF_LEN - CP_LEN) % HALF_LEN);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(HALF_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CP,
        ST_HALF1,
        ST_HALF2,
        ST_PAYLOAD
    } state_t;

    state_t              r_state;
    state_t              w_next_phase;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_remain;
    logic [ITEM_W-1:0]   r_tdata;
    logic                r_tvalid;
    logic                r_tlast;
    logic [15:0]         r_frame_cnt;
    logic [ITEM_W-1:0]   r_ram [HALF_LEN];

    logic                w_load;
    logic                w_in_take;
    logic                w_in_fire;
    logic                w_last_fire;
    logic                w_start;
    logic [LEN_W-1:0]    w_len;
    logic [ITEM_W-1:0]   w_ram_rd;
    logic                w_unused;

    // Framing comes only from the configured length, so the input tlast is
    // deliberately left unused.
    assign w_unused = s_axis_tlast;

    // The output register may take a new sample when it is empty or when its
    // current sample is being handed over this cycle.
    assign w_load      = !r_tvalid || m_axis_tready;

    // Payload is pulled only in PAYLOAD while samples are still owed. Once the
    // final sample is in the output register, r_remain is zero and input is
    // refused until the next frame.
    assign w_in_take   = (r_state == ST_PAYLOAD) && w_load && (r_remain != '0);
    assign w_in_fire   = w_in_take && s_axis_tvalid;
    assign w_last_fire = r_tvalid && r_tlast && m_axis_tready;
    assign w_start     = cfg_enable && s_axis_tvalid;
    assign w_len       = (cfg_payload_len == '0) ? LEN_W'(1) : cfg_payload_len;

    // The asynchronous RAM read feeds the output register directly. That
    // register is the single cycle of read latency. Because r_addr advances
    // only on a load, backpressure can neither skip nor repeat a preamble
    // sample.
    assign w_ram_rd    = r_ram[r_addr];

    assign s_axis_tready = w_in_take;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign busy          = (r_state != ST_IDLE);
    assign frame_cnt     = r_frame_cnt;

    // Successor of each preamble phase, used when the read address reaches
    // the end of the RAM.
    always_comb begin
        w_next_phase = ST_IDLE;
        case (r_state)
            ST_CP:    w_next_phase = ST_HALF1;
            ST_HALF1: w_next_phase = ST_HALF2;
            ST_HALF2: w_next_phase = ST_PAYLOAD;
            default:  w_next_phase = ST_IDLE;
        endcase
    end

    // Preamble RAM. It has no reset, so its contents survive ce_rst.
    // Software may rewrite it only between frames; a write that lands while
    // a frame is being emitted is dropped so the preamble cannot change
    // mid-frame.
    always_ff @(posedge ce_clk) begin
        if (pre_wr_en && (r_state == ST_IDLE)) begin
            r_ram[pre_wr_addr] <= pre_wr_data;
        end
    end

    // Framing state machine and registered output stage.
    //
    // All three preamble phases walk the same address counter. Because
    // HALF_LEN is a power of two, r_addr wraps to zero naturally after the
    // last entry. Each phase therefore ends when the last address is loaded,
    // and the next phase starts at address 0.
    //
    // The frame ends on the tlast handshake, not on acceptance of the last
    // input sample. busy therefore stays high until the frame has fully left
    // the block, and the RAM stays locked against writes until then.
    always_ff @(posedge ce_clk) begin
        if (ce_rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_remain    <= '0;
            r_tdata     <= '0;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        r_tvalid <= 1'b0;
                        r_tlast  <= 1'b0;
                    end
                    if (w_start) begin
                        r_remain <= w_len;
                        r_addr   <= CP_START;
                        if (CP_LEN > 0) begin
                            r_state <= ST_CP;
                        end else begin
                            r_state <= ST_HALF1;
                        end
                    end
                end

                ST_CP, ST_HALF1, ST_HALF2: begin
                    if (w_load) begin
                        r_tdata  <= w_ram_rd;
                        r_tvalid <= 1'b1;
                        r_tlast  <= 1'b0;
                        r_addr   <= r_addr + ADDR_W'(1);
                        if (r_addr == LAST_ADDR) begin
                            r_state <= w_next_phase;
                        end
                    end
                end

                ST_PAYLOAD: begin
                    if (w_in_fire) begin
                        r_tdata  <= s_axis_tdata;
                        r_tvalid <= 1'b1;
                        r_tlast  <= (r_remain == LEN_W'(1));
                        r_remain <= r_remain - LEN_W'(1);
                    end else if (w_load) begin
                        r_tvalid <= 1'b0;
                        r_tlast  <= 1'b0;
                    end
                    if (w_last_fire) begin
                        r_state     <= ST_IDLE;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_schmidl_cox_preamble_inserter.sv
// ============================================================================
// tb_schmidl_cox_preamble_inserter
//
// Directed bench for the preamble inserter.
//
// Configuration: HALF_LEN = 4, CP_LEN = 2. The RAM holds 0x00010001 ..
// 0x00040004, so every frame opens with the ten samples
// 03,04,01,02,03,04,01,02,03,04 (each multiplied by 0x00010001), followed by
// the payload words 0xA000000n.
//
// A passive monitor records every output handshake and counts accepted
// inputs. The payload source always presents the next word the frame should
// carry.
// ============================================================================
module tb_schmidl_cox_preamble_inserter;

    localparam int ITEM_W   = 32;
    localparam int HALF_LEN = 4;
    localparam int CP_LEN   = 2;
    localparam int LEN_W    = 16;
    localparam int PRE_LEN  = CP_LEN + 2 * HALF_LEN;

    logic              ce_clk = 1'b0;
    logic              ce_rst = 1'b1;
    logic              cfg_enable = 1'b0;
    logic [LEN_W-1:0]  cfg_payload_len = '0;
    logic              pre_wr_en = 1'b0;
    logic [1:0]        pre_wr_addr = '0;
    logic [ITEM_W-1:0] pre_wr_data = '0;
    wire  [ITEM_W-1:0] s_axis_tdata;
    logic              s_axis_tvalid = 1'b0;
    wire               s_axis_tready;
    logic              s_axis_tlast = 1'b0;
    wire  [ITEM_W-1:0] m_axis_tdata;
    wire               m_axis_tvalid;
    logic              m_axis_tready = 1'b0;
    wire               m_axis_tlast;
    wire               busy;
    wire  [15:0]       frame_cnt;

    int checkCount = 0;
    int errorCount = 0;

    logic [31:0] outData [$];
    bit          outLast [$];
    int          inCount = 0;
    int          lastCount = 0;
    int          stallErrors = 0;
    logic        stallPending = 1'b0;
    logic [31:0] stallData = '0;
    logic        stallLast = 1'b0;
    int          curLen = 1;
    int          payloadBase = 0;

    logic [31:0] expPre [PRE_LEN] = '{32'h00030003, 32'h00040004,
                                      32'h00010001, 32'h00020002, 32'h00030003, 32'h00040004,
                                      32'h00010001, 32'h00020002, 32'h00030003, 32'h00040004};

    // The payload source always offers the next word of the current frame.
    assign s_axis_tdata = 32'hA000_0000 + 32'((inCount - payloadBase) % curLen);

    schmidl_cox_preamble_inserter #(
        .ITEM_W   (ITEM_W),
        .HALF_LEN (HALF_LEN),
        .CP_LEN   (CP_LEN),
        .LEN_W    (LEN_W)
    ) dut (
        .ce_clk          (ce_clk),
        .ce_rst          (ce_rst),
        .cfg_enable      (cfg_enable),
        .cfg_payload_len (cfg_payload_len),
        .pre_wr_en       (pre_wr_en),
        .pre_wr_addr     (pre_wr_addr),
        .pre_wr_data     (pre_wr_data),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .s_axis_tlast    (s_axis_tlast),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tlast    (m_axis_tlast),
        .busy            (busy),
        .frame_cnt       (frame_cnt)
    );

    // 100 MHz block clock.
    always #5 ce_clk = ~ce_clk;

    // Passive monitor. It logs output handshakes and counts accepted inputs.
    // It also notes any change to a sample held under backpressure.
    always @(posedge ce_clk) begin
        if (ce_rst) begin
            stallPending <= 1'b0;
        end else begin
            if (m_axis_tvalid && m_axis_tready) begin
                outData.push_back(m_axis_tdata);
                outLast.push_back(m_axis_tlast);
                if (m_axis_tlast) lastCount <= lastCount + 1;
            end
            if (s_axis_tvalid && s_axis_tready) inCount <= inCount + 1;
            if (stallPending && (!m_axis_tvalid || m_axis_tdata !== stallData || m_axis_tlast !== stallLast))
                stallErrors <= stallErrors + 1;
            stallPending <= m_axis_tvalid && !m_axis_tready;
            stallData    <= m_axis_tdata;
            stallLast    <= m_axis_tlast;
        end
    end

    // Hard stop in case the run loses its way.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Writes one preamble RAM entry through the write port.
    task automatic writeRam(input logic [1:0] addr, input logic [31:0] data);
        @(negedge ce_clk);
        pre_wr_en   = 1'b1;
        pre_wr_addr = addr;
        pre_wr_data = data;
        @(negedge ce_clk);
        pre_wr_en   = 1'b0;
    endtask

    // Drives payload and downstream ready until the tlast count reaches the
    // target or the cycle budget runs out. Each signal stalls randomly with
    // the given percentage.
    task automatic runFrames(input int target, input int stallPct, input int budget, output bit timedOut);
        int cycles;
        cycles = 0;
        s_axis_tvalid = 1'b1;
        m_axis_tready = 1'b1;
        while (lastCount < target && cycles < budget) begin
            @(negedge ce_clk);
            cycles++;
            if (lastCount < target) begin
                s_axis_tvalid = ($urandom_range(99) >= stallPct);
                m_axis_tready = ($urandom_range(99) >= stallPct);
            end
        end
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        timedOut = (lastCount < target);
    endtask

    // Reset leaves every output at its reset value.
    task automatic test_reset;
        ce_rst = 1'b1;
        repeat (3) @(negedge ce_clk);
        checkCount++; if (m_axis_tvalid !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_tvalid got %0b want 0", m_axis_tvalid); end
        checkCount++; if (m_axis_tlast !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_tlast got %0b want 0", m_axis_tlast); end
        checkCount++; if (m_axis_tdata !== 32'h0) begin errorCount++; $display("[TB] FAIL reset_tdata got %h want 0", m_axis_tdata); end
        checkCount++; if (s_axis_tready !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_tready got %0b want 0", s_axis_tready); end
        checkCount++; if (busy !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_busy got %0b want 0", busy); end
        checkCount++; if (frame_cnt !== 16'h0) begin errorCount++; $display("[TB] FAIL reset_frame_cnt got %h want 0", frame_cnt); end
        ce_rst = 1'b0;
        writeRam(2'd0, 32'h00010001);
        writeRam(2'd1, 32'h00020002);
        writeRam(2'd2, 32'h00030003);
        writeRam(2'd3, 32'h00040004);
    endtask

    // One frame with continuous input and no backpressure: start latency,
    // frame contents, tlast placement and the counter.
    task automatic test_basic_frame;
        int  qb;
        int  ib;
        bit  to;
        logic [31:0] expD;
        qb = outData.size();
        ib = inCount;
        cfg_payload_len = 16'd3;
        curLen = 3;
        payloadBase = inCount;
        cfg_enable = 1'b1;
        m_axis_tready = 1'b1;
        @(negedge ce_clk);
        s_axis_tvalid = 1'b1;
        @(negedge ce_clk);
        checkCount++; if (busy !== 1'b1) begin errorCount++; $display("[TB] FAIL basic_busy_t1 got %0b want 1", busy); end
        checkCount++; if (m_axis_tvalid !== 1'b0) begin errorCount++; $display("[TB] FAIL basic_tvalid_t1 got %0b want 0", m_axis_tvalid); end
        @(negedge ce_clk);
        checkCount++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h00030003) begin
            errorCount++; $display("[TB] FAIL basic_first_sample got v=%0b d=%h want v=1 d=00030003", m_axis_tvalid, m_axis_tdata);
        end
        runFrames(lastCount + 1, 0, 100, to);
        checkCount++; if (to) begin errorCount++; $display("[TB] FAIL basic_timeout got no tlast want tlast within budget"); end
        checkCount++; if (outData.size() - qb !== PRE_LEN + 3) begin errorCount++; $display("[TB] FAIL basic_length got %0d want %0d", outData.size() - qb, PRE_LEN + 3); end
        for (int i = 0; i < PRE_LEN + 3; i++) begin
            expD = (i < PRE_LEN) ? expPre[i] : 32'hA000_0000 + 32'(i - PRE_LEN);
            checkCount++;
            if (outData[qb + i] !== expD || outLast[qb + i] !== (i == PRE_LEN + 2)) begin
                errorCount++; $display("[TB] FAIL basic_sample[%0d] got d=%h l=%0b want d=%h l=%0b", i, outData[qb + i], outLast[qb + i], expD, (i == PRE_LEN + 2));
            end
        end
        checkCount++; if (frame_cnt !== 16'd1) begin errorCount++; $display("[TB] FAIL basic_frame_cnt got %0d want 1", frame_cnt); end
        checkCount++; if (inCount - ib !== 3) begin errorCount++; $display("[TB] FAIL basic_inputs got %0d want 3", inCount - ib); end
    endtask

    // Twenty frames with random stalls on both sides. Content must be
    // identical to the basic frame, and held samples must never change.
    task automatic test_backpressure;
        int  qb;
        int  ib;
        int  sb;
        bit  to;
        bit  bad;
        int  badIdx;
        logic [31:0] expD;
        ce_rst = 1'b1;
        @(negedge ce_clk);
        ce_rst = 1'b0;
        qb = outData.size();
        ib = inCount;
        sb = stallErrors;
        curLen = 3;
        payloadBase = inCount;
        runFrames(lastCount + 20, 25, 5000, to);
        @(negedge ce_clk);
        checkCount++; if (to) begin errorCount++; $display("[TB] FAIL bp_timeout got %0d frames want 20", frame_cnt); end
        checkCount++; if (outData.size() - qb !== 20 * (PRE_LEN + 3)) begin errorCount++; $display("[TB] FAIL bp_length got %0d want %0d", outData.size() - qb, 20 * (PRE_LEN + 3)); end
        for (int f = 0; f < 20; f++) begin
            bad = 1'b0;
            badIdx = 0;
            for (int i = 0; i < PRE_LEN + 3; i++) begin
                expD = (i < PRE_LEN) ? expPre[i] : 32'hA000_0000 + 32'(i - PRE_LEN);
                if (!bad && (outData[qb + f * (PRE_LEN + 3) + i] !== expD || outLast[qb + f * (PRE_LEN + 3) + i] !== (i == PRE_LEN + 2))) begin
                    bad = 1'b1;
                    badIdx = i;
                end
            end
            checkCount++;
            if (bad) begin
                errorCount++; $display("[TB] FAIL bp_frame[%0d] sample %0d got %h want %h", f, badIdx, outData[qb + f * (PRE_LEN + 3) + badIdx],
                                       (badIdx < PRE_LEN) ? expPre[badIdx] : 32'hA000_0000 + 32'(badIdx - PRE_LEN));
            end
        end
        checkCount++; if (stallErrors - sb !== 0) begin errorCount++; $display("[TB] FAIL bp_stall_stability got %0d changes want 0", stallErrors - sb); end
        checkCount++; if (frame_cnt !== 16'd20) begin errorCount++; $display("[TB] FAIL bp_frame_cnt got %0d want 20", frame_cnt); end
        checkCount++; if (inCount - ib !== 60) begin errorCount++; $display("[TB] FAIL bp_inputs got %0d want 60", inCount - ib); end
    endtask

    // A zero payload length behaves as a single-sample payload.
    task automatic test_zero_length;
        int  qb;
        int  ib;
        bit  to;
        logic [31:0] expD;
        qb = outData.size();
        ib = inCount;
        cfg_payload_len = 16'd0;
        curLen = 1;
        payloadBase = inCount;
        runFrames(lastCount + 1, 0, 100, to);
        repeat (3) @(negedge ce_clk);
        checkCount++; if (to) begin errorCount++; $display("[TB] FAIL zero_timeout got no tlast want tlast within budget"); end
        checkCount++; if (outData.size() - qb !== PRE_LEN + 1) begin errorCount++; $display("[TB] FAIL zero_length got %0d want %0d", outData.size() - qb, PRE_LEN + 1); end
        for (int i = 0; i < PRE_LEN + 1; i++) begin
            expD = (i < PRE_LEN) ? expPre[i] : 32'hA000_0000;
            checkCount++;
            if (outData[qb + i] !== expD || outLast[qb + i] !== (i == PRE_LEN)) begin
                errorCount++; $display("[TB] FAIL zero_sample[%0d] got d=%h l=%0b want d=%h l=%0b", i, outData[qb + i], outLast[qb + i], expD, (i == PRE_LEN));
            end
        end
        checkCount++; if (inCount - ib !== 1) begin errorCount++; $display("[TB] FAIL zero_inputs got %0d want 1", inCount - ib); end
        checkCount++; if (frame_cnt !== 16'd21) begin errorCount++; $display("[TB] FAIL zero_frame_cnt got %0d want 21", frame_cnt); end
        cfg_payload_len = 16'd3;
        curLen = 3;
        payloadBase = inCount;
    endtask

    // A RAM write issued mid-frame is dropped; the same write issued while
    // idle takes effect in both half-symbols of the next frame.
    task automatic test_ram_write_busy;
        int  qb;
        bit  to;
        logic [31:0] expD;
        qb = outData.size();
        payloadBase = inCount;
        m_axis_tready = 1'b1;
        s_axis_tvalid = 1'b1;
        @(negedge ce_clk);
        checkCount++; if (busy !== 1'b1) begin errorCount++; $display("[TB] FAIL wrbusy_busy got %0b want 1", busy); end
        pre_wr_en   = 1'b1;
        pre_wr_addr = 2'd0;
        pre_wr_data = 32'hDEADBEEF;
        @(negedge ce_clk);
        pre_wr_en   = 1'b0;
        runFrames(lastCount + 1, 0, 100, to);
        checkCount++; if (to) begin errorCount++; $display("[TB] FAIL wrbusy_timeout got no tlast want tlast within budget"); end
        checkCount++; if (outData[qb + 2] !== 32'h00010001) begin errorCount++; $display("[TB] FAIL wrbusy_dropped got %h want 00010001", outData[qb + 2]); end
        checkCount++; if (outData[qb + 6] !== 32'h00010001) begin errorCount++; $display("[TB] FAIL wrbusy_dropped_h2 got %h want 00010001", outData[qb + 6]); end

        writeRam(2'd0, 32'hDEADBEEF);
        qb = outData.size();
        payloadBase = inCount;
        runFrames(lastCount + 1, 0, 100, to);
        checkCount++; if (to) begin errorCount++; $display("[TB] FAIL wridle_timeout got no tlast want tlast within budget"); end
        for (int i = 0; i < PRE_LEN + 3; i++) begin
            expD = (i < PRE_LEN) ? expPre[i] : 32'hA000_0000 + 32'(i - PRE_LEN);
            if (i == 2 || i == 6) expD = 32'hDEADBEEF;
            checkCount++;
            if (outData[qb + i] !== expD) begin
                errorCount++; $display("[TB] FAIL wridle_sample[%0d] got %h want %h", i, outData[qb + i], expD);
            end
        end
        writeRam(2'd0, 32'h00010001);
    endtask

    // Reset during the second half-symbol discards the partial frame and
    // leaves the RAM intact for the following frame.
    task automatic test_reset_mid_frame;
        int  qb;
        int  lb;
        int  cycles;
        bit  to;
        logic [31:0] expD;
        qb = outData.size();
        lb = lastCount;
        payloadBase = inCount;
        m_axis_tready = 1'b1;
        s_axis_tvalid = 1'b1;
        cycles = 0;
        while (outData.size() < qb + 7 && cycles < 30) begin
            @(negedge ce_clk);
            cycles++;
        end
        checkCount++; if (outData.size() < qb + 7) begin errorCount++; $display("[TB] FAIL rstmid_reach got %0d samples want 7", outData.size() - qb); end
        checkCount++; if (busy !== 1'b1 || m_axis_tdata !== 32'h00020002) begin
            errorCount++; $display("[TB] FAIL rstmid_in_half2 got busy=%0b d=%h want busy=1 d=00020002", busy, m_axis_tdata);
        end
        ce_rst = 1'b1;
        s_axis_tvalid = 1'b0;
        @(negedge ce_clk);
        checkCount++; if (m_axis_tvalid !== 1'b0) begin errorCount++; $display("[TB] FAIL rstmid_tvalid got %0b want 0", m_axis_tvalid); end
        checkCount++; if (m_axis_tlast !== 1'b0) begin errorCount++; $display("[TB] FAIL rstmid_tlast got %0b want 0", m_axis_tlast); end
        checkCount++; if (m_axis_tdata !== 32'h0) begin errorCount++; $display("[TB] FAIL rstmid_tdata got %h want 0", m_axis_tdata); end
        checkCount++; if (s_axis_tready !== 1'b0) begin errorCount++; $display("[TB] FAIL rstmid_tready got %0b want 0", s_axis_tready); end
        checkCount++; if (busy !== 1'b0) begin errorCount++; $display("[TB] FAIL rstmid_busy got %0b want 0", busy); end
        checkCount++; if (frame_cnt !== 16'h0) begin errorCount++; $display("[TB] FAIL rstmid_frame_cnt got %h want 0", frame_cnt); end
        checkCount++; if (lastCount !== lb) begin errorCount++; $display("[TB] FAIL rstmid_no_tlast got %0d tlasts want 0", lastCount - lb); end
        ce_rst = 1'b0;
        @(negedge ce_clk);
        qb = outData.size();
        payloadBase = inCount;
        runFrames(lastCount + 1, 0, 100, to);
        checkCount++; if (to) begin errorCount++; $display("[TB] FAIL rstmid_timeout got no tlast want tlast within budget"); end
        for (int i = 0; i < PRE_LEN + 3; i++) begin
            expD = (i < PRE_LEN) ? expPre[i] : 32'hA000_0000 + 32'(i - PRE_LEN);
            checkCount++;
            if (outData[qb + i] !== expD || outLast[qb + i] !== (i == PRE_LEN + 2)) begin
                errorCount++; $display("[TB] FAIL rstmid_sample[%0d] got d=%h l=%0b want d=%h l=%0b", i, outData[qb + i], outLast[qb + i], expD, (i == PRE_LEN + 2));
            end
        end
        checkCount++; if (frame_cnt !== 16'd1) begin errorCount++; $display("[TB] FAIL rstmid_frame_cnt_after got %0d want 1", frame_cnt); end
    endtask

    // With cfg_enable low nothing starts. A frame completed with the counter
    // preset to 0xFFFF wraps it to zero.
    task automatic test_disable_wrap;
        int  ib;
        int  qb;
        bit  to;
        ib = inCount;
        qb = outData.size();
        cfg_enable = 1'b0;
        s_axis_tvalid = 1'b1;
        m_axis_tready = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge ce_clk);
            checkCount++;
            if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0 || busy !== 1'b0) begin
                errorCount++; $display("[TB] FAIL disabled_cycle[%0d] got v=%0b r=%0b b=%0b want 0 0 0", c, m_axis_tvalid, s_axis_tready, busy);
            end
        end
        s_axis_tvalid = 1'b0;
        checkCount++; if (inCount - ib !== 0 || outData.size() - qb !== 0) begin
            errorCount++; $display("[TB] FAIL disabled_traffic got in=%0d out=%0d want 0 0", inCount - ib, outData.size() - qb);
        end
        cfg_enable = 1'b1;
        force dut.r_frame_cnt = 16'hFFFF;
        @(negedge ce_clk);
        release dut.r_frame_cnt;
        @(negedge ce_clk);
        checkCount++; if (frame_cnt !== 16'hFFFF) begin errorCount++; $display("[TB] FAIL wrap_preset got %h want ffff", frame_cnt); end
        payloadBase = inCount;
        runFrames(lastCount + 1, 0, 100, to);
        checkCount++; if (to) begin errorCount++; $display("[TB] FAIL wrap_timeout got no tlast want tlast within budget"); end
        checkCount++; if (frame_cnt !== 16'h0000) begin errorCount++; $display("[TB] FAIL wrap_frame_cnt got %h want 0000", frame_cnt); end
    endtask

    // Scenario sequence.
    initial begin
        $display("[TB] starting preamble inserter bench");
        test_reset;
        test_basic_frame;
        test_backpressure;
        test_zero_length;
        test_ram_write_busy;
        test_reset_mid_frame;
        test_disable_wrap;
        repeat (2) @(negedge ce_clk);
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/schmidl_cox_preamble_inserter.md
# schmidl_cox_preamble_inserter

Transmit-side counterpart of the Schmidl-Cox detector: prepends a Schmidl-Cox synchronization preamble to each outgoing OFDM frame. The preamble is an optional cyclic prefix followed by two identical half-symbols, stored in a software-loadable RAM. The payload stream follows the preamble, and the block asserts tlast on the final payload sample. It sits in the ce_clk domain of an RFNoC TX block, between the AXI-stream sample interface from the NoC shell and the radio/DUC path.

## Interface

**Parameters**
- ITEM_W, 32, sample width (sc16: I in [31:16], Q in [15:0])
- HALF_LEN, 64, samples per preamble half-symbol; power of two, 2..1024
- CP_LEN, 16, cyclic-prefix samples before the preamble; 0..HALF_LEN
- LEN_W, 16, width of the payload length configuration

**Ports**
- ce_clk  in  1  block clock
- ce_rst  in  1  synchronous reset, active-high
- cfg_enable  in  1  1 = frames may start
- cfg_payload_len  in  LEN_W  payload samples per frame; latched at frame start
- pre_wr_en  in  1  preamble RAM write strobe
- pre_wr_addr  in  log2(HALF_LEN)  preamble RAM write address
- pre_wr_data  in  ITEM_W  preamble RAM write data
- s_axis_tdata  in  ITEM_W  payload samples
- s_axis_tvalid  in  1  payload valid
- s_axis_tready  out  1  payload accepted
- s_axis_tlast  in  1  ignored; framing comes from cfg_payload_len
- m_axis_tdata  out  ITEM_W  framed output samples
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  last sample of the frame
- busy  out  1  frame in progress (state ≠ IDLE)
- frame_cnt  out  16  completed frames, wraps at 2^16

## Operation

**State machine:** IDLE → CP → HALF1 → HALF2 → PAYLOAD → IDLE.
- **IDLE:** start condition is cfg_enable && s_axis_tvalid.
  - On start, latch len = max(cfg_payload_len, 1). A value of 0 is treated as 1.
  - Next state is CP if CP_LEN > 0, otherwise HALF1.
- **CP:** emits RAM[HALF_LEN-CP_LEN .. HALF_LEN-1] in ascending address order.
- **HALF1:** emits RAM[0 .. HALF_LEN-1].
- **HALF2:** emits RAM[0 .. HALF_LEN-1] again.
- **PAYLOAD:** passes exactly len input samples through unmodified.
  - m_axis_tlast = 1 on the len-th sample.
  - When that sample is accepted (tvalid && tready), frame_cnt increments and the state returns to IDLE.
- **Payload backpressure:** s_axis_tready = 1 only in PAYLOAD, and only while the output register can load (!m_axis_tvalid || m_axis_tready). s_axis_tready = 0 in every other state.
- **Input stalls:** if s_axis_tvalid drops mid-payload, m_axis_tvalid deasserts and the frame waits indefinitely. There is no timeout.
- **Mid-frame disable:** cfg_enable is sampled only in IDLE. Deasserting it mid-frame does not truncate the current frame.
- **Preamble RAM:**
  - Writes are accepted only while busy = 0. Writes while busy = 1 are dropped.
  - Contents are not cleared by ce_rst. Contents are undefined until written.
- **Counters:** frame_cnt wraps 0xFFFF → 0x0000.

## Timing

- **Reset values:** m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0, s_axis_tready = 0, busy = 0, frame_cnt = 0, state = IDLE.
- **Reset mid-frame:** the next cycle shows the reset values. The partial frame is discarded with no tlast. RAM contents are retained.
- **Output stage:** outputs are registered. tdata and tlast are held stable while tvalid && !tready.
- **Start latency:** the start condition is seen at edge t. busy = 1 from t+1. The first m_axis_tvalid (first CP sample) appears at t+2; the RAM read has 1-cycle latency.
- **Throughput:** with m_axis_tready = 1 and s_axis_tvalid = 1 continuously, the frame is gapless. It emits 1 sample/cycle for CP_LEN + 2·HALF_LEN + len cycles.
- **Preamble backpressure:** while m_axis_tready = 0 during the preamble, the RAM read address must not advance. No sample is skipped or duplicated.
- **Back-to-back frames:** at most 3 idle output cycles between tlast of frame N and the first sample of frame N+1 when input is continuously valid.
- **Counter update:** frame_cnt updates on the edge after the tlast handshake.

## Test plan

Parameters for all scenarios: HALF_LEN = 4, CP_LEN = 2. RAM = {0x00010001, 0x00020002, 0x00030003, 0x00040004}. len = 3. Payload D0..D2 = 0xA000000n.

1. **Basic frame.** Continuous input, m_axis_tready = 1.
   - Output: 03,04,01,02,03,04,01,02,03,04 (×0x00010001), then D0,D1,D2.
   - tlast only on D2. First tvalid 2 cycles after s_axis_tvalid rises. frame_cnt = 1.
2. **Random backpressure.** 25% m_axis_tready stalls and 25% s_axis_tvalid gaps, 20 frames.
   - Output sequence is identical to scenario 1, repeated 20 times. tdata is stable during stalls. frame_cnt = 20.
3. **Zero length.** cfg_payload_len = 0.
   - Frame is 10 preamble samples + 1 payload sample, with tlast on that payload sample. Exactly 1 input sample is consumed.
4. **RAM write while busy.** Write 0xDEADBEEF to addr 0 while busy = 1; the write is dropped, so the next frame's HALF1[0] = 0x00010001. The same write with busy = 0 makes the next frame's HALF1[0] = 0xDEADBEEF.
5. **Reset mid-frame.** Assert ce_rst during HALF2 sample 2.
   - All outputs return to their reset values and frame_cnt = 0.
   - The next frame is complete and correct without reloading the RAM.
6. **Disable and counter wrap.**
   - cfg_enable = 0 with s_axis_tvalid = 1 for 50 cycles: no output, s_axis_tready = 0 throughout.
   - Force frame_cnt = 0xFFFF, then run 1 frame: frame_cnt = 0x0000.
